// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared definitions for the PC redirect sequencer:
//   state_t    - sequencer states (RUN, HOLD, DRAIN, KENTER)
//   kind_t     - redirect kind encoding; a larger value means a higher priority
//   PRIO_ORDER - kinds listed from highest to lowest priority, 3 bits per rank
//   prio_at()  - returns the kind found at a given priority rank (0 = highest)
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_KENTER = 2'd3
    } state_t;

    localparam int KIND_W    = 3;
    localparam int NUM_KINDS = 7;
    localparam int NUM_PRIO  = 6;

    typedef enum logic [KIND_W-1:0] {
        KIND_NONE     = 3'd0,
        KIND_JUMP     = 3'd1,
        KIND_BRANCH   = 3'd2,
        KIND_PRED     = 3'd3,
        KIND_MISSPRED = 3'd4,
        KIND_EXC      = 3'd5,
        KIND_ERET     = 3'd6
    } kind_t;

    // Rank 0 sits in the least significant bits, so eret is the first entry checked.
    localparam logic [NUM_PRIO*KIND_W-1:0] PRIO_ORDER = {
        KIND_JUMP, KIND_BRANCH, KIND_PRED, KIND_MISSPRED, KIND_EXC, KIND_ERET
    };

    function automatic kind_t prio_at(input int rank);
        return kind_t'(PRIO_ORDER[rank*KIND_W +: KIND_W]);
    endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// redirect_prio_enc
// Combinational priority picker for redirect requests.
// Ports:
//   req    [NUM_KINDS-1:0]       - one bit per kind, indexed by kind_t value
//   tgt    [NUM_KINDS-1:0][31:0] - target for each kind, indexed the same way
//   kind   kind_t                - highest-priority active kind, KIND_NONE if idle
//   target [31:0]                - target of the selected kind, 0 if idle
module redirect_prio_enc
    import pc_ctrl_pkg::*;
(
    input  logic [NUM_KINDS-1:0]       req,
    input  logic [NUM_KINDS-1:0][31:0] tgt,
    output kind_t                      kind,
    output logic [31:0]                target
);

    logic found;

    // Walk the priority table from the top and keep the first active request.
    always_comb begin
        kind   = KIND_NONE;
        target = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            if (!found && req[prio_at(i)]) begin
                kind   = prio_at(i);
                target = tgt[prio_at(i)];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Sequences the pc register. It merges redirect requests from the pipeline
// stages, holds the winner while fetch is stalled, and runs exception entry
// (flush, drain, kernel entry). It also keeps the kernel-mode flag and two
// saturating statistics counters.
// Ports:
//   clk, reset (sync, active-high)
//   stall_fetch, pipe_empty                     - pipeline status
//   req_* / tgt_*                               - redirect request pulses and their targets
//   pc_we, is_* , dst_redirect                  - one-hot select, write enable and target for pc
//   flush_frontend, flush_backend               - pipeline kill strobes
//   kernel_mode                                 - registered privilege flag
//   stat_redirects, stat_misspred [CNT_W-1:0]   - saturating event counters
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_fetch,
    input  logic             pipe_empty,
    input  logic             req_eret,
    input  logic             req_exc,
    input  logic             req_misspred,
    input  logic             req_pred,
    input  logic             req_branch,
    input  logic             req_jump,
    input  logic [31:0]      tgt_eret,
    input  logic [31:0]      tgt_misspred,
    input  logic [31:0]      tgt_pred,
    input  logic [31:0]      tgt_branch,
    input  logic [31:0]      tgt_jump,
    output logic             pc_we,
    output logic             is_eret,
    output logic             is_kernel,
    output logic             is_misspred,
    output logic             is_bpredictor,
    output logic             is_branch,
    output logic             is_jump,
    output logic [31:0]      dst_redirect,
    output logic             flush_frontend,
    output logic             flush_backend,
    output logic             kernel_mode,
    output logic [CNT_W-1:0] stat_redirects,
    output logic [CNT_W-1:0] stat_misspred
);

    state_t                     state_q, state_d;
    kind_t                      pend_kind_q, pend_kind_d;
    logic [31:0]                pend_tgt_q, pend_tgt_d;
    logic                       kernel_q, kernel_d;
    logic [CNT_W-1:0]           redir_cnt_q, mis_cnt_q;

    logic [NUM_KINDS-1:0]       new_req, merge_req;
    logic [NUM_KINDS-1:0][31:0] new_tgt, merge_tgt;
    kind_t                      new_kind, sel_kind;
    logic [31:0]                new_target, sel_target;

    kind_t                      commit_kind;
    logic [31:0]                commit_tgt;
    logic                       we_c, kernel_sel_c, flush_fe_c, flush_be_c;
    logic                       redirect_fire;

    // Gather incoming requests by kind. An eret outside kernel mode is masked
    // here, so an exception raised in the same cycle is not blocked by it.
    always_comb begin
        new_req                = '0;
        new_tgt                = '0;
        new_req[KIND_JUMP]     = req_jump;
        new_req[KIND_BRANCH]   = req_branch;
        new_req[KIND_PRED]     = req_pred;
        new_req[KIND_MISSPRED] = req_misspred;
        new_req[KIND_EXC]      = req_exc;
        new_req[KIND_ERET]     = req_eret & kernel_q;
        new_tgt[KIND_JUMP]     = tgt_jump;
        new_tgt[KIND_BRANCH]   = tgt_branch;
        new_tgt[KIND_PRED]     = tgt_pred;
        new_tgt[KIND_MISSPRED] = tgt_misspred;
        new_tgt[KIND_ERET]     = tgt_eret;
    end

    redirect_prio_enc u_new_enc (
        .req    (new_req),
        .tgt    (new_tgt),
        .kind   (new_kind),
        .target (new_target)
    );

    // Only the new winner competes with the pending entry. The pending entry
    // is written last, so on a tie of kinds the older target is kept.
    always_comb begin
        merge_req           = '0;
        merge_tgt           = '0;
        merge_req[new_kind] = (new_kind != KIND_NONE);
        merge_tgt[new_kind] = new_target;
        if (pend_kind_q != KIND_NONE) begin
            merge_req[pend_kind_q] = 1'b1;
            merge_tgt[pend_kind_q] = pend_tgt_q;
        end
    end

    redirect_prio_enc u_merge_enc (
        .req    (merge_req),
        .tgt    (merge_tgt),
        .kind   (sel_kind),
        .target (sel_target)
    );

    // Next-state and output decode. The pending register is empty in RUN, so
    // RUN and HOLD share one path driven by the merged selection.
    always_comb begin
        state_d      = state_q;
        pend_kind_d  = pend_kind_q;
        pend_tgt_d   = pend_tgt_q;
        kernel_d     = kernel_q;
        commit_kind  = KIND_NONE;
        commit_tgt   = '0;
        we_c         = 1'b0;
        kernel_sel_c = 1'b0;
        flush_fe_c   = 1'b0;
        flush_be_c   = 1'b0;
        unique case (state_q)
            ST_RUN, ST_HOLD: begin
                if (sel_kind == KIND_EXC) begin
                    flush_fe_c  = 1'b1;
                    flush_be_c  = 1'b1;
                    pend_kind_d = KIND_NONE;
                    pend_tgt_d  = '0;
                    state_d     = pipe_empty ? ST_KENTER : ST_DRAIN;
                end else if (sel_kind == KIND_NONE) begin
                    we_c = !stall_fetch;
                end else if (stall_fetch) begin
                    pend_kind_d = sel_kind;
                    pend_tgt_d  = sel_target;
                    state_d     = ST_HOLD;
                end else begin
                    we_c        = 1'b1;
                    commit_kind = sel_kind;
                    commit_tgt  = sel_target;
                    flush_fe_c  = (sel_kind != KIND_PRED);
                    pend_kind_d = KIND_NONE;
                    pend_tgt_d  = '0;
                    state_d     = ST_RUN;
                    if (sel_kind == KIND_ERET) begin
                        kernel_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_KENTER;
                end
            end
            ST_KENTER: begin
                we_c         = 1'b1;
                kernel_sel_c = 1'b1;
                kernel_d     = 1'b1;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign redirect_fire = we_c && (kernel_sel_c || (commit_kind != KIND_NONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pend_kind_q <= KIND_NONE;
            pend_tgt_q  <= '0;
            kernel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_kind_q <= pend_kind_d;
            pend_tgt_q  <= pend_tgt_d;
            kernel_q    <= kernel_d;
        end
    end

    // Statistics counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_cnt_q <= '0;
            mis_cnt_q   <= '0;
        end else begin
            if (redirect_fire && (redir_cnt_q != {CNT_W{1'b1}})) begin
                redir_cnt_q <= redir_cnt_q + CNT_W'(1);
            end
            if ((commit_kind == KIND_MISSPRED) && (mis_cnt_q != {CNT_W{1'b1}})) begin
                mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
        end
    end

    // Every output is forced low while reset is high, including the registered ones.
    assign pc_we          = !reset && we_c;
    assign is_eret        = !reset && (commit_kind == KIND_ERET);
    assign is_kernel      = !reset && kernel_sel_c;
    assign is_misspred    = !reset && (commit_kind == KIND_MISSPRED);
    assign is_bpredictor  = !reset && (commit_kind == KIND_PRED);
    assign is_branch      = !reset && (commit_kind == KIND_BRANCH);
    assign is_jump        = !reset && (commit_kind == KIND_JUMP);
    assign dst_redirect   = reset ? '0 : commit_tgt;
    assign flush_frontend = !reset && flush_fe_c;
    assign flush_backend  = !reset && flush_be_c;
    assign kernel_mode    = !reset && kernel_q;
    assign stat_redirects = reset ? '0 : redir_cnt_q;
    assign stat_misspred  = reset ? '0 : mis_cnt_q;

endmodule
